mines_input_controller: RTL and testbench

MINES_INPUT_CONTROLLER -- requirements
Module: mines_input_controller

---
 rtl/mines_input_controller.sv | 142 ++++++++++++++
 tb/tb_mines_input_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mines_input_controller.sv
// Input front end for a 4x4 mines game: two debounced active-low buttons move a
// cursor and reveal tiles until the game ends or every tile is revealed.

module mines_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_n,
  output logic o_press
);
  localparam logic [19:0] CNT_MAX = 20'(DEBOUNCE_CYCLES);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_db;
  logic        r_db_q;
  logic [19:0] r_cnt;
  logic [19:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + 20'd1;

  // db resets low (pressed) so a button held through reset cannot fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_db_q  <= 1'b0;
      r_cnt   <= 20'd0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      if (r_sync2 == r_db) begin
        r_cnt <= 20'd0;
      end else if (w_cnt_inc == CNT_MAX) begin
        r_db  <= r_sync2;
        r_cnt <= 20'd0;
      end else begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  // Falling edge of the debounced level is a press; release is silent.
  assign o_press = r_db_q & ~r_db;
endmodule

module mines_input_controller #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_reveal_n,
  input  logic        btn_next_n,
  input  logic        game_over,
  input  logic        game_won,
  output logic [3:0]  tile_idx,
  output logic        reveal_pulse,
  output logic [3:0]  reveal_tile,
  output logic [15:0] revealed_map,
  output logic [4:0]  reveal_count,
  output logic        locked
);
  typedef enum logic {S_PLAY = 1'b0, S_LOCK = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_rev_press;
  logic        w_nxt_press;
  logic        w_lock_req;
  logic        w_do_reveal;
  logic        w_do_next;
  logic [3:0]  r_tile;
  logic        r_pulse;
  logic [3:0]  r_rtile;
  logic [15:0] r_map;
  logic [4:0]  r_count;

  mines_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_reveal (
    .clk     (clk),
    .rst     (rst),
    .i_btn_n (btn_reveal_n),
    .o_press (w_rev_press)
  );

  mines_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk     (clk),
    .rst     (rst),
    .i_btn_n (btn_next_n),
    .o_press (w_nxt_press)
  );

  assign w_lock_req = game_over | game_won | (r_count == 5'd16);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_PLAY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_PLAY && w_lock_req) w_state_nxt = S_LOCK;
  end

  // The lock request itself already gates events, so a reveal coinciding
  // with game end is dropped rather than slipping in before LOCK.
  always_comb begin
    locked      = (r_state == S_LOCK);
    w_do_reveal = 1'b0;
    w_do_next   = 1'b0;
    if (r_state == S_PLAY && !w_lock_req) begin
      w_do_reveal = w_rev_press & ~r_map[r_tile];
      w_do_next   = w_nxt_press;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tile  <= 4'd0;
      r_pulse <= 1'b0;
      r_rtile <= 4'd0;
      r_map   <= 16'd0;
      r_count <= 5'd0;
    end else begin
      r_pulse <= w_do_reveal;
      if (w_do_reveal) begin
        r_rtile        <= r_tile;
        r_map[r_tile]  <= 1'b1;
        r_count        <= r_count + 5'd1;
      end
      if (w_do_next) r_tile <= r_tile + 4'd1;
    end
  end

  assign tile_idx     = r_tile;
  assign reveal_pulse = r_pulse;
  assign reveal_tile  = r_rtile;
  assign revealed_map = r_map;
  assign reveal_count = r_count;
endmodule

// File: tb/tb_mines_input_controller.sv
// Directed bench for mines_input_controller with a short debounce window.

module tb_mines_input_controller;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_reveal_n;
  logic        btn_next_n;
  logic        game_over;
  logic        game_won;
  logic [3:0]  tile_idx;
  logic        reveal_pulse;
  logic [3:0]  reveal_tile;
  logic [15:0] revealed_map;
  logic [4:0]  reveal_count;
  logic        locked;

  mines_input_controller #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_reveal_n (btn_reveal_n),
    .btn_next_n   (btn_next_n),
    .game_over    (game_over),
    .game_won     (game_won),
    .tile_idx     (tile_idx),
    .reveal_pulse (reveal_pulse),
    .reveal_tile  (reveal_tile),
    .revealed_map (revealed_map),
    .reveal_count (reveal_count),
    .locked       (locked)
  );

  always #10 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  int         pulses   = 0;
  int         pulse_at = -1;
  int         cyc_no   = 0;
  logic [3:0] last_rt  = 4'd0;

  typedef struct {
    string       nm;
    logic        rev;
    logic        nxt;
    logic        go;
    int          hold;
    int          exp_p;
    logic [3:0]  exp_rt;
    logic [3:0]  exp_idx;
    logic [15:0] exp_map;
    logic [4:0]  exp_cnt;
    logic        exp_lk;
  } vec_t;

  vec_t vt[8];

  function automatic vec_t mk(input string nm, input logic rev, input logic nxt,
                              input logic go, input int hold, input int exp_p,
                              input logic [3:0] exp_rt, input logic [3:0] exp_idx,
                              input logic [15:0] exp_map, input logic [4:0] exp_cnt,
                              input logic exp_lk);
    vec_t v;
    v.nm = nm; v.rev = rev; v.nxt = nxt; v.go = go; v.hold = hold;
    v.exp_p = exp_p; v.exp_rt = exp_rt; v.exp_idx = exp_idx;
    v.exp_map = exp_map; v.exp_cnt = exp_cnt; v.exp_lk = exp_lk;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_no++;
    if (reveal_pulse === 1'b1) begin
      pulses++;
      last_rt  = reveal_tile;
      pulse_at = cyc_no;
    end
  endtask

  // Hold the selected buttons low for 'hold' cycles, then release long
  // enough for the release to debounce.
  task automatic press(input logic rev, input logic nxt, input int hold, input logic go);
    game_over    = go;
    btn_reveal_n = ~rev;
    btn_next_n   = ~nxt;
    repeat (hold) tick();
    btn_reveal_n = 1'b1;
    btn_next_n   = 1'b1;
    repeat (10) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tile_idx"}, tile_idx, 4'd0);
    chk({tag, "_pulse"}, reveal_pulse, 1'b0);
    chk({tag, "_reveal_tile"}, reveal_tile, 4'd0);
    chk({tag, "_map"}, revealed_map, 16'h0000);
    chk({tag, "_count"}, reveal_count, 5'd0);
    chk({tag, "_locked"}, locked, 1'b0);
  endtask

  initial begin
    logic found;
    rst = 1'b1; btn_reveal_n = 1'b1; btn_next_n = 1'b1;
    game_over = 1'b0; game_won = 1'b0;

    vt[0] = mk("glitch_next_3",   0, 1, 0, 3, 0, 4'd0, 4'd0, 16'h0001, 5'd1, 0);
    vt[1] = mk("rereveal_tile0",  1, 0, 0, 6, 0, 4'd0, 4'd0, 16'h0001, 5'd1, 0);
    vt[2] = mk("next_hold_4",     0, 1, 0, 4, 0, 4'd0, 4'd2, 16'h0001, 5'd1, 0);
    vt[3] = mk("next_to_3",       0, 1, 0, 6, 0, 4'd0, 4'd3, 16'h0001, 5'd1, 0);
    vt[4] = mk("rev_and_next",    1, 1, 0, 6, 1, 4'd3, 4'd4, 16'h0009, 5'd2, 0);
    vt[5] = mk("reveal_tile4",    1, 0, 0, 6, 1, 4'd4, 4'd4, 16'h0019, 5'd3, 0);
    vt[6] = mk("locked_by_over",  1, 1, 1, 6, 0, 4'd4, 4'd4, 16'h0019, 5'd3, 1);
    vt[7] = mk("stays_locked",    1, 0, 0, 6, 0, 4'd4, 4'd4, 16'h0019, 5'd3, 1);

    do_reset();
    chk_reset_vals("reset");
    repeat (10) tick();

    // First reveal: pulse must appear right after edge DB+2 of the low level.
    btn_reveal_n = 1'b0;
    pulses = 0; cyc_no = -1; pulse_at = -1;
    repeat (10) tick();
    btn_reveal_n = 1'b1;
    repeat (10) tick();
    chk("first_pulse_count", pulses, 1);
    chk("first_pulse_cycle", pulse_at, DB + 2);
    chk("first_reveal_tile", last_rt, 4'd0);
    chk("first_map", revealed_map, 16'h0001);
    chk("first_count", reveal_count, 5'd1);

    for (int i = 0; i < 2; i++) begin
      pulses = 0;
      press(vt[i].rev, vt[i].nxt, vt[i].hold, vt[i].go);
      chk({vt[i].nm, "_pulses"}, pulses, vt[i].exp_p);
      chk({vt[i].nm, "_tile_idx"}, tile_idx, vt[i].exp_idx);
      chk({vt[i].nm, "_map"}, revealed_map, vt[i].exp_map);
      chk({vt[i].nm, "_count"}, reveal_count, vt[i].exp_cnt);
    end

    pulses = 0;
    for (int i = 0; i < 17; i++) press(1'b0, 1'b1, 6, 1'b0);
    chk("next17_tile_idx", tile_idx, 4'd1);
    chk("next17_pulses", pulses, 0);

    for (int i = 2; i < 8; i++) begin
      pulses = 0;
      press(vt[i].rev, vt[i].nxt, vt[i].hold, vt[i].go);
      chk({vt[i].nm, "_pulses"}, pulses, vt[i].exp_p);
      chk({vt[i].nm, "_reveal_tile"}, reveal_tile, vt[i].exp_rt);
      chk({vt[i].nm, "_tile_idx"}, tile_idx, vt[i].exp_idx);
      chk({vt[i].nm, "_map"}, revealed_map, vt[i].exp_map);
      chk({vt[i].nm, "_count"}, reveal_count, vt[i].exp_cnt);
      chk({vt[i].nm, "_locked"}, locked, vt[i].exp_lk);
    end

    do_reset();
    chk_reset_vals("relock_reset");
    repeat (10) tick();

    // game_won rising in the same cycle as the reveal event.
    btn_reveal_n = 1'b0; pulses = 0; cyc_no = -1;
    repeat (DB + 2) tick();
    game_won = 1'b1;
    repeat (4) tick();
    game_won = 1'b0;
    btn_reveal_n = 1'b1;
    repeat (10) tick();
    chk("won_same_cycle_pulses", pulses, 0);
    chk("won_same_cycle_map", revealed_map, 16'h0000);
    chk("won_same_cycle_locked", locked, 1'b1);

    do_reset();
    repeat (10) tick();

    // Reset landing on the event cycle, button kept held through reset.
    btn_reveal_n = 1'b0; pulses = 0; cyc_no = -1;
    repeat (DB + 2) tick();
    rst = 1'b1;
    tick();
    chk("rst_cycle_pulse", reveal_pulse, 1'b0);
    rst = 1'b0;
    tick();
    chk("post_rst_pulse", reveal_pulse, 1'b0);
    repeat (10) tick();
    btn_reveal_n = 1'b1;
    repeat (10) tick();
    chk("held_through_rst_pulses", pulses, 0);
    chk("held_through_rst_map", revealed_map, 16'h0000);
    pulses = 0;
    press(1'b1, 1'b0, 6, 1'b0);
    chk("repress_after_rst_pulses", pulses, 1);
    chk("repress_after_rst_map", revealed_map, 16'h0001);

    do_reset();
    repeat (10) tick();

    // Reveal the whole board.
    for (int i = 0; i < 15; i++) begin
      pulses = 0;
      press(1'b1, 1'b0, 6, 1'b0);
      chk($sformatf("board_pulse_%0d", i), pulses, 1);
      chk($sformatf("board_tile_%0d", i), last_rt, i[3:0]);
      press(1'b0, 1'b1, 6, 1'b0);
    end
    btn_reveal_n = 1'b0; pulses = 0; found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (reveal_pulse === 1'b1) found = 1'b1;
    end
    chk("last_pulse_seen", found, 1'b1);
    chk("last_reveal_tile", reveal_tile, 4'd15);
    chk("lock_at_last_pulse", locked, 1'b0);
    tick();
    chk("lock_after_last_pulse", locked, 1'b1);
    chk("no_pulse_after_last", reveal_pulse, 1'b0);
    btn_reveal_n = 1'b1;
    repeat (10) tick();
    press(1'b0, 1'b1, 6, 1'b0);
    chk("full_count", reveal_count, 5'd16);
    chk("full_map", revealed_map, 16'hFFFF);
    chk("full_tile_idx_held", tile_idx, 4'd15);
    chk("full_locked", locked, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
